// File: rtl/ecc_t_bank.sv
// ecc_t_bank -- ECC core T register bank with word-serial unload port.
//
// Holds the x, y, s operand/result registers used while sequencing ECDH,
// ECDSA-sign and ECDSA-verify. The controller updates them via t_op/t_en/t_clr.
// The host drains them WORD bits at a time over a valid/ready port.
// Loads are refused (lock_err) while an unload is in progress.
//
// Parameters:
//   WIDTH  register / operand width (default 256)
//   WORD   unload word width (default 32); WIDTH must be a multiple of WORD
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   t_op, t_en, t_clr       update select, load enable, synchronous clear
//   ecp1_xp, ecp1_yp,
//   ecp3_xp, ecp3_yp        point-unit results
//   in_kr, in_ds, hash_msg  host operands
//   rd_start, rd_sel        start unload; 0 x, 1 y, 2 s, 3 x then y then s
//   rd_data, rd_valid,
//   rd_ready, rd_last       unload word stream, LS word first
//   busy                    unload in progress
//   lock_err                one-cycle pulse: t_en dropped because busy
//   veri_ok                 registered ECDSA verify result
//   x, y, s                 register contents
//
// Optional build macro ECC_T_RDCHK_EN: appends one checksum beat (XOR of all
// sent words) after the data words; rd_last then sits on the checksum beat.

module ecc_t_bank #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned WORD  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       t_op,
   input  logic             t_en,
   input  logic             t_clr,
   input  logic [WIDTH-1:0] ecp1_xp,
   input  logic [WIDTH-1:0] ecp1_yp,
   input  logic [WIDTH-1:0] ecp3_xp,
   input  logic [WIDTH-1:0] ecp3_yp,
   input  logic [WIDTH-1:0] in_kr,
   input  logic [WIDTH-1:0] in_ds,
   input  logic [WIDTH-1:0] hash_msg,
   input  logic             rd_start,
   input  logic [1:0]       rd_sel,
   output logic [WORD-1:0]  rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             rd_last,
   output logic             busy,
   output logic             lock_err,
   output logic             veri_ok,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] s
);

   localparam int unsigned NW = WIDTH / WORD;
   localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic [2:0] {
      OP_ECDH_RES  = 3'd0,
      OP_VERI_INIT = 3'd1,
      OP_VERI_SWAP = 3'd2,
      OP_VERI_SETU = 3'd3,
      OP_VERI_U2P  = 3'd4,
      OP_VERI_RES  = 3'd5,
      OP_SIGN_INIT = 3'd6,
      OP_SIGN_RES  = 3'd7
   } op_e;

`ifdef ECC_T_RDCHK_EN
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_CHK} state_e;
`else
   typedef enum logic {S_IDLE, S_SEND} state_e;
`endif

   state_e           state_q, state_d;
   logic [CW-1:0]    word_cnt;
   logic [1:0]       reg_idx;    // 0 x, 1 y, 2 s
   logic             multi_q;    // rd_sel == 3: walk x, y, s in turn
   logic             beat;
   logic             final_word;
   logic [WIDTH-1:0] cur_reg;
   logic [WORD-1:0]  cur_word;
`ifdef ECC_T_RDCHK_EN
   logic [WORD-1:0]  chk;
`endif

   assert property (@(posedge clk) (WIDTH % WORD) == 0)
      else $error("ecc_t_bank: WIDTH must be a multiple of WORD");

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x        <= '0;
         y        <= '0;
         s        <= '0;
         veri_ok  <= 1'b0;
         lock_err <= 1'b0;
      end else begin
         lock_err <= 1'b0;
         if (t_clr) begin
            x       <= '0;
            y       <= '0;
            s       <= '0;
            veri_ok <= 1'b0;
         end else if (t_en) begin
            if (busy) begin
               lock_err <= 1'b1;
            end else begin
               case (op_e'(t_op))
                  OP_ECDH_RES, OP_SIGN_RES: begin
                     x <= ecp3_xp;
                     y <= ecp3_yp;
                     s <= '0;
                  end
                  OP_VERI_U2P: begin
                     x <= ecp3_xp;
                     y <= ecp3_yp;
                  end
                  OP_VERI_INIT: begin
                     x       <= hash_msg;
                     y       <= in_kr;
                     s       <= in_ds;
                     veri_ok <= 1'b0;
                  end
                  OP_VERI_SWAP: begin
                     x <= ecp1_xp;
                     y <= ecp1_yp;
                  end
                  OP_VERI_SETU: begin
                     x <= ecp3_xp;
                     y <= ecp3_yp;
                     s <= ecp1_yp;
                  end
                  OP_VERI_RES: begin
                     // compare uses the pre-update s
                     x       <= ecp3_xp;
                     y       <= WIDTH'(s == ecp3_xp);
                     s       <= '0;
                     veri_ok <= (s == ecp3_xp);
                  end
                  OP_SIGN_INIT: begin
                     x <= in_ds;
                     y <= hash_msg;
                     s <= in_kr;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // ------------------------------------------------------- word selection
   always_comb begin
      cur_reg = '0;
      case (reg_idx)
         2'd0:    cur_reg = x;
         2'd1:    cur_reg = y;
         2'd2:    cur_reg = s;
         default: cur_reg = '0;
      endcase
   end

   assign cur_word   = cur_reg[int'(word_cnt) * WORD +: WORD];
   assign beat       = (state_q == S_SEND) && rd_ready;
   assign final_word = (word_cnt == CW'(NW - 1)) && (!multi_q || reg_idx == 2'd2);

   // ------------------------------------------------------ unload FSM: state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ------------------------------------------------- unload FSM: next state
   always_comb begin
      state_d = state_q;
      if (t_clr) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (rd_start) state_d = S_SEND;
`ifdef ECC_T_RDCHK_EN
            S_SEND: if (beat && final_word) state_d = S_CHK;
            S_CHK:  if (rd_ready) state_d = S_IDLE;
`else
            S_SEND: if (beat && final_word) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------- unload FSM: outputs
   always_comb begin
      rd_valid = (state_q != S_IDLE);
      busy     = (state_q != S_IDLE);
      rd_data  = '0;
      rd_last  = 1'b0;
      case (state_q)
         S_SEND: begin
            rd_data = cur_word;
`ifndef ECC_T_RDCHK_EN
            rd_last = final_word;
`endif
         end
`ifdef ECC_T_RDCHK_EN
         S_CHK: begin
            rd_data = chk;
            rd_last = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // ---------------------------------------------------- unload counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         reg_idx  <= '0;
         multi_q  <= 1'b0;
`ifdef ECC_T_RDCHK_EN
         chk      <= '0;
`endif
      end else if (t_clr) begin
         word_cnt <= '0;
         reg_idx  <= '0;
         multi_q  <= 1'b0;
`ifdef ECC_T_RDCHK_EN
         chk      <= '0;
`endif
      end else if (state_q == S_IDLE && rd_start) begin
         word_cnt <= '0;
         multi_q  <= (rd_sel == 2'd3);
         reg_idx  <= (rd_sel == 2'd3) ? 2'd0 : rd_sel;
`ifdef ECC_T_RDCHK_EN
         chk      <= '0;
`endif
      end else if (beat) begin
`ifdef ECC_T_RDCHK_EN
         chk <= chk ^ cur_word;
`endif
         // only the multi-register walk advances reg_idx meaningfully; the
         // unload ends on final_word before reg_idx could run past s
         if (word_cnt == CW'(NW - 1)) begin
            word_cnt <= '0;
            reg_idx  <= reg_idx + 2'd1;
         end else begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/ecc_t_bank.md
Name: ecc_t_bank

Overview:
- Parametrised successor of the ECC core T register bank: holds the three operand/result registers x, y, s for ECDH, ECDSA-sign and ECDSA-verify sequencing.
- Adds a word-serial unload port with a valid/ready handshake, so the SPI host side can drain results WORD bits at a time.
- Adds a registered verify flag and write-lock protection while an unload is in progress.
- Sits between the ECC controller (t_op/t_en/t_clr) and the host interface.

Parameters:
- WIDTH, 256, bit width of x, y, s and of all point/scalar inputs.
- WORD, 32, unload word width. WIDTH must be an integer multiple of WORD, checked by a simulation-time assertion.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- t_op  in  3  update select: 0 ECDH_RES, 1 VERI_INIT, 2 VERI_SWAP, 3 VERI_SETU, 4 VERI_U2P, 5 VERI_RES, 6 SIGN_INIT, 7 SIGN_RES
- t_en  in  1  load x/y/s per t_op
- t_clr  in  1  synchronous clear of x/y/s, veri_ok and the unload FSM
- ecp1_xp, ecp1_yp, ecp3_xp, ecp3_yp  in  WIDTH each  point-unit results
- in_kr, in_ds, hash_msg  in  WIDTH each  host operands
- rd_start  in  1  start unload (pulse)
- rd_sel  in  2  0 x, 1 y, 2 s, 3 x then y then s
- rd_data  out  WORD  unload word
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accept
- rd_last  out  1  final word of the unload
- busy  out  1  unload in progress
- lock_err  out  1  one-cycle pulse: t_en was dropped because busy was high
- veri_ok  out  1  registered ECDSA verify result
- x, y, s  out  WIDTH each  register contents

Behaviour:
- Reset: x, y, s, rd_data = 0; rd_valid, rd_last, busy, lock_err, veri_ok = 0; FSM in IDLE.
- Priority, in order: t_clr > t_en. t_clr zeroes x/y/s, clears veri_ok, forces the FSM to IDLE and drops rd_valid the next cycle, aborting any unload. No rd_last is issued on abort.
- Load when t_en=1 and busy=0 (one-cycle latency), by t_op:
  - ECDH_RES, VERI_U2P, SIGN_RES: x = ecp3_xp, y = ecp3_yp. s = 0 for ECDH_RES/SIGN_RES; s held for VERI_U2P.
  - VERI_INIT: x = hash_msg, y = in_kr, s = in_ds.
  - VERI_SWAP: x = ecp1_xp, y = ecp1_yp, s held.
  - VERI_SETU: x = ecp3_xp, y = ecp3_yp, s = ecp1_yp.
  - VERI_RES: eq = (s == ecp3_xp) using the pre-update s; x = ecp3_xp, y = {0, eq}, s = 0, veri_ok = eq.
  - SIGN_INIT: x = in_ds, y = hash_msg, s = in_kr.
- veri_ok is otherwise held; cleared by t_clr or by a t_en load with t_op = VERI_INIT.
- t_en while busy=1: registers unchanged, lock_err=1 for one cycle.
- Unload FSM states:
  - IDLE: rd_start (with t_clr=0) latches rd_sel and clears the word counter -> SEND. busy=1 from the next cycle.
  - SEND: rd_valid=1 with rd_data = current word of the selected register, least-significant word first. Beat completes on rd_valid & rd_ready, then counter+1. rd_data/rd_valid held stable while rd_ready=0.
  - Words per unload: N = WIDTH/WORD, or 3N for rd_sel=3 (x words 0..N-1, then y, then s).
  - rd_last=1 with the final word. On its accept -> IDLE the same edge; rd_valid and busy go low the next cycle.
- rd_start while busy is ignored. rd_start and t_en in the same IDLE cycle: the load happens first, so the unload sends the newly loaded values.
- The counter never wraps: it is terminated by rd_last.

Optional Feature:
- Macro ECC_T_RDCHK_EN.
- When defined: after the last data word, one extra beat carries the XOR of all sent words. rd_last moves to this checksum beat; the checksum register is reset on each rd_start.
- When undefined: no checksum beat and no checksum logic; rd_last sits on the last data word.

Test Plan:
- SIGN_INIT with in_ds=0x11, hash_msg=0x22, in_kr=0x33, t_en=1 -> next cycle x=0x11, y=0x22, s=0x33.
- s loaded with value A via VERI_INIT (in_ds=A), then VERI_RES with ecp3_xp=A -> y=1, s=0, veri_ok=1. Repeat with ecp3_xp=A^1 -> y=0, veri_ok=0.
- Defaults, x=0x0807…0201 pattern, rd_sel=0, rd_ready always 1 -> 8 beats, LS word first, rd_last on beat 8, busy low afterward. With ECC_T_RDCHK_EN: 9 beats, beat 9 = XOR of beats 1-8, rd_last on beat 9.
- rd_sel=3 with rd_ready toggling 1-0-1 -> 24 beats in order x, y, s; data stable while rd_ready=0; rd_last only on the final beat.
- t_en during an unload -> registers unchanged, lock_err pulses once. t_clr at beat 4 -> rd_valid low next cycle, busy=0, x=y=s=0, no rd_last.
- rst_n asserted mid-unload and asynchronous to clk -> all outputs 0 immediately. A new rd_start after release restarts at word 0.
